// File: rtl/piso_bar_pkg.sv
// Shared definitions for the piso_bar parallel-in serial-out barrel:
// default datapath geometry, the IDLE/SHIFT state encoding and a
// ceiling-log2 helper used to size the beat counter.
package piso_bar_pkg;

  // Default geometry: one serial chunk is DATA_WIDTH*IF_WIDTH bits and a
  // parallel word carries KERNEL_WIDTH chunks.
  localparam int DATA_WIDTH   = 8;
  localparam int IF_WIDTH     = 1;
  localparam int KERNEL_WIDTH = 3;

  // IDLE: the shift register is empty. SHIFT: it holds a word being emitted.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int c_log_2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/piso_hold.sv
// One-word hold buffer for piso_bar. It captures a parallel word that
// arrives while the shift register is still busy, and releases it when the
// shift register frees. The full flag gates par_ready in the parent.
module piso_hold #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             pop,
  output logic [WIDTH-1:0] hold_data,
  output logic             hold_full
);

  logic [WIDTH-1:0] data_reg;
  logic             full_reg;

  // Capture on load, clear the flag on pop. The parent only loads while the
  // buffer is empty and only pops while it is full, so the two never collide.
  always_ff @(posedge clk) begin
    if (!reset) begin
      data_reg <= '0;
      full_reg <= 1'b0;
    end else if (load) begin
      data_reg <= load_data;
      full_reg <= 1'b1;
    end else if (pop) begin
      full_reg <= 1'b0;
    end
  end

  assign hold_data = data_reg;
  assign hold_full = full_reg;

endmodule

// File: rtl/piso_bar.sv
// piso_bar: double-buffered parallel-in serial-out barrel. A wide word is
// taken on a valid/ready handshake and emitted NUM chunks at a time on a
// serial valid/ready stream with first/last markers. A one-word hold buffer
// lets the next word be accepted while the current one is shifting, so
// back-to-back words stream without a bubble.
// Build option: define PISO_BAR_LSB_FIRST_EN for LSB-first chunk order;
// the default build emits MSB-first.
module piso_bar
  import piso_bar_pkg::*;
#(
  parameter int SER_WIDTH = DATA_WIDTH * IF_WIDTH,
  parameter int PAR_WIDTH = DATA_WIDTH * IF_WIDTH * KERNEL_WIDTH,
  parameter int NUM       = PAR_WIDTH / SER_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PAR_WIDTH-1:0] par_in,
  input  logic                 par_valid,
  output logic                 par_ready,
  output logic [SER_WIDTH-1:0] ser_out,
  output logic                 ser_valid,
  input  logic                 ser_ready,
  output logic                 ser_first,
  output logic                 ser_last,
  output logic                 busy
);

  localparam int CNT_W = (c_log_2(NUM) < 1) ? 1 : c_log_2(NUM);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM - 1);

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [PAR_WIDTH-1:0] sreg_reg, sreg_next;

  logic                 hold_full;
  logic [PAR_WIDTH-1:0] hold_data;
  logic                 hold_load;
  logic                 hold_pop;

  logic par_hs;
  logic beat;
  logic at_last;
  logic sreg_free;
  logic bypass;

  // Handshake qualifiers. par_ready includes reset so nothing is accepted
  // while the block is held in reset.
  assign par_ready = reset && !hold_full;
  assign par_hs    = par_valid && par_ready;
  assign beat      = ser_valid && ser_ready;
  assign at_last   = (cnt_reg == CNT_LAST);
  assign sreg_free = (state_reg == ST_IDLE) || (beat && at_last);
  // A word goes straight into the shift register only when it frees this
  // cycle and no older word is waiting in the hold buffer.
  assign bypass    = sreg_free && !hold_full && par_hs;

  // Next-state logic: reload from hold or bypass when the shift register
  // frees, otherwise shift one chunk per beat.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sreg_next  = sreg_reg;
    hold_pop   = 1'b0;
    hold_load  = par_hs && !bypass;

    if (sreg_free) begin
      if (hold_full) begin
        sreg_next  = hold_data;
        hold_pop   = 1'b1;
        cnt_next   = '0;
        state_next = ST_SHIFT;
      end else if (par_hs) begin
        sreg_next  = par_in;
        cnt_next   = '0;
        state_next = ST_SHIFT;
      end else begin
        // Clear the datapath so an idle stream shows zeros.
        sreg_next  = '0;
        cnt_next   = '0;
        state_next = ST_IDLE;
      end
    end else if (beat) begin
`ifdef PISO_BAR_LSB_FIRST_EN
      sreg_next = sreg_reg >> SER_WIDTH;
`else
      sreg_next = sreg_reg << SER_WIDTH;
`endif
      cnt_next  = cnt_reg + CNT_W'(1);
    end
  end

  // State, beat counter and shift register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      sreg_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      sreg_reg  <= sreg_next;
    end
  end

  piso_hold #(
    .WIDTH(PAR_WIDTH)
  ) u_hold (
    .clk      (clk),
    .reset    (reset),
    .load     (hold_load),
    .load_data(par_in),
    .pop      (hold_pop),
    .hold_data(hold_data),
    .hold_full(hold_full)
  );

  // Output chunk comes from the end of the register the shift moves toward,
  // so a stalled beat keeps presenting the same chunk.
`ifdef PISO_BAR_LSB_FIRST_EN
  assign ser_out = sreg_reg[SER_WIDTH-1:0];
`else
  assign ser_out = sreg_reg[PAR_WIDTH-1 -: SER_WIDTH];
`endif

  assign ser_valid = (state_reg == ST_SHIFT);
  assign ser_first = ser_valid && (cnt_reg == '0);
  assign ser_last  = ser_valid && at_last;
  assign busy      = ser_valid || hold_full;

endmodule

// File: tb/tb_piso_bar.sv
// Directed testbench for piso_bar with SER_WIDTH=8, PAR_WIDTH=24, NUM=3.
// Outputs are sampled 1 ns after each rising edge; inputs are changed at
// the same point so they are stable well before the next edge.
module tb_piso_bar;

  localparam int SW = 8;
  localparam int PW = 24;
  localparam int N  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [PW-1:0] par_in = '0;
  logic          par_valid = 1'b0;
  logic          par_ready;
  logic [SW-1:0] ser_out;
  logic          ser_valid;
  logic          ser_ready = 1'b0;
  logic          ser_first;
  logic          ser_last;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  piso_bar #(
    .SER_WIDTH(SW),
    .PAR_WIDTH(PW),
    .NUM      (N)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .par_in   (par_in),
    .par_valid(par_valid),
    .par_ready(par_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_first(ser_first),
    .ser_last (ser_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Chunk i of word w in emission order.
  function automatic logic [SW-1:0] chunk_of(input logic [PW-1:0] w, input int i);
`ifdef PISO_BAR_LSB_FIRST_EN
    return w[SW*i +: SW];
`else
    return w[SW*(N-1-i) +: SW];
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [PW-1:0] w, input int i);
    check({tag, "_valid"}, 32'(ser_valid), 32'd1);
    check({tag, "_data"},  32'(ser_out), 32'(chunk_of(w, i)));
    check({tag, "_first"}, 32'(ser_first), 32'(i == 0));
    check({tag, "_last"},  32'(ser_last), 32'(i == N - 1));
    $display("beat %s: word %06h chunk %0d data %02h", tag, w, i, ser_out);
  endtask

  task automatic expect_reset_outputs(input string tag);
    check({tag, "_ser_out"},   32'(ser_out), 32'd0);
    check({tag, "_ser_valid"}, 32'(ser_valid), 32'd0);
    check({tag, "_ser_first"}, 32'(ser_first), 32'd0);
    check({tag, "_ser_last"},  32'(ser_last), 32'd0);
    check({tag, "_busy"},      32'(busy), 32'd0);
    check({tag, "_par_ready"}, 32'(par_ready), 32'd0);
  endtask

  // Watchdog: the directed sequence is short; anything past this is a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PW-1:0] acc;
    logic [19:0]   pat;
    logic          done;
    int            nbeats;

    // Reset state
    reset = 1'b0;
    repeat (3) step();
    expect_reset_outputs("rst");
    reset = 1'b1;
    #1;
    check("rst_release_par_ready", 32'(par_ready), 32'd1);
    $display("txn reset: outputs checked");

    // Single word 0xAABBCC at full rate
    ser_ready = 1'b1;
    par_in    = 24'hAABBCC;
    par_valid = 1'b1;
    step();
    par_valid = 1'b0;
    expect_beat("single0", 24'hAABBCC, 0);
    step();
    expect_beat("single1", 24'hAABBCC, 1);
    step();
    expect_beat("single2", 24'hAABBCC, 2);
    step();
    check("single_end_valid", 32'(ser_valid), 32'd0);
    check("single_end_busy", 32'(busy), 32'd0);
    $display("txn single: word aabbcc");

    // Back-to-back words: second word parks in hold, stream has no gap
    par_in    = 24'h112233;
    par_valid = 1'b1;
    step();
    expect_beat("b2b0", 24'h112233, 0);
    par_in = 24'h445566;
    check("b2b_ready_before_hold", 32'(par_ready), 32'd1);
    step();
    par_valid = 1'b0;
    expect_beat("b2b1", 24'h112233, 1);
    check("b2b_hold_par_ready", 32'(par_ready), 32'd0);
    check("b2b_hold_busy", 32'(busy), 32'd1);
    step();
    expect_beat("b2b2", 24'h112233, 2);
    check("b2b_full_par_ready", 32'(par_ready), 32'd0);
    step();
    expect_beat("b2b3", 24'h445566, 0);
    check("b2b_drained_par_ready", 32'(par_ready), 32'd1);
    step();
    expect_beat("b2b4", 24'h445566, 1);
    step();
    expect_beat("b2b5", 24'h445566, 2);
    step();
    check("b2b_end_valid", 32'(ser_valid), 32'd0);
    $display("txn back-to-back: words 112233 445566");

    // Backpressure after the first beat
    par_in    = 24'hAABBCC;
    par_valid = 1'b1;
    step();
    par_valid = 1'b0;
    expect_beat("stall0", 24'hAABBCC, 0);
    step();
    expect_beat("stall1", 24'hAABBCC, 1);
    ser_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      expect_beat($sformatf("stall_hold%0d", k), 24'hAABBCC, 1);
    end
    ser_ready = 1'b1;
    step();
    expect_beat("stall2", 24'hAABBCC, 2);
    step();
    check("stall_end_valid", 32'(ser_valid), 32'd0);
    $display("txn stall: word aabbcc with 3 wait cycles");

    // Reset in mid-word while a second word is held
    par_in    = 24'h112233;
    par_valid = 1'b1;
    step();
    expect_beat("mid0", 24'h112233, 0);
    par_in = 24'h445566;
    step();
    par_valid = 1'b0;
    expect_beat("mid1", 24'h112233, 1);
    check("mid_busy_held", 32'(busy), 32'd1);
    reset = 1'b0;
    step();
    expect_reset_outputs("mid_rst");
    reset = 1'b1;
    #1;
    check("mid_release_par_ready", 32'(par_ready), 32'd1);
    check("mid_release_busy", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("mid_after%0d_valid", k), 32'(ser_valid), 32'd0);
    end
    $display("txn mid-word reset: words discarded");

    // Loopback reconstruction under an irregular ready pattern
    par_in    = 24'hA1B2C3;
    par_valid = 1'b1;
    step();
    par_valid = 1'b0;
    pat    = 20'b1101_0011_0101_1010_0110;
    acc    = '0;
    done   = 1'b0;
    nbeats = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      ser_ready = pat[k];
      if (ser_valid && ser_ready) begin
        if (ser_first) acc = '0;
`ifdef PISO_BAR_LSB_FIRST_EN
        acc = {ser_out, acc[PW-1:SW]};
`else
        acc = {acc[PW-SW-1:0], ser_out};
`endif
        nbeats++;
        if (ser_last) done = 1'b1;
      end
      step();
    end
    check("loop_done", 32'(done), 32'd1);
    check("loop_beats", 32'(nbeats), 32'd3);
    check("loop_word", 32'(acc), 32'h00A1B2C3);
    ser_ready = 1'b1;
    step();
    check("loop_end_valid", 32'(ser_valid), 32'd0);
    $display("txn loopback: rebuilt %06h", acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/piso_bar.md
# piso_bar

Parallel-in serial-out barrel: the transmit-side counterpart of the activation/weight SIPO path. It accepts one wide word (`KERNEL_WIDTH` chunks of `DATA_WIDTH*IF_WIDTH` bits) over a valid/ready handshake and emits it chunk by chunk on a serial valid/ready stream, with first/last markers. It sits between PE-array result rows and the memory-controller write path. It is double-buffered, so a word can be delivered every NUM cycles with no bubble.

## Interface
- `SER_WIDTH`, default `` `DATA_WIDTH*`IF_WIDTH ``: width of one serial chunk.
- `PAR_WIDTH`, default `` `DATA_WIDTH*`IF_WIDTH*`KERNEL_WIDTH ``: width of the parallel word.
- `NUM`, default `PAR_WIDTH/SER_WIDTH`: beats per word; must be ≥1; `PAR_WIDTH` must be an exact multiple of `SER_WIDTH`.
- `clk` input 1: the single clock; all state changes on its rising edge.
- `reset` input 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `par_in` input PAR_WIDTH: parallel word, sampled on a par handshake.
- `par_valid` input 1: `par_in` is valid.
- `par_ready` output 1: the block can accept a word this cycle.
- `ser_out` output SER_WIDTH: current serial chunk.
- `ser_valid` output 1: `ser_out` is valid.
- `ser_ready` input 1: the downstream stage accepts `ser_out` this cycle.
- `ser_first` output 1: the current beat is chunk 0 of a word.
- `ser_last` output 1: the current beat is chunk NUM-1 of a word.
- `busy` output 1: the shift register or the hold buffer holds data.

## Operation
- Storage: the shift register `sreg` with beat counter `cnt` (width max(1, `` `C_LOG_2(NUM) ``)), plus a one-word hold buffer with flag `hold_full`.
- States: IDLE (sreg empty) and SHIFT (sreg holds a word).
- Handshakes:
  - par handshake = `par_valid && par_ready`.
  - beat = `ser_valid && ser_ready`.
- `par_ready = reset && !hold_full`.
- `sreg` frees this cycle when state is IDLE, or when a beat occurs with `cnt==NUM-1`.
- Loading `sreg` when it frees:
  - If hold is full: hold → `sreg`, hold clears, `cnt←0`, next state SHIFT.
  - Else, if a par handshake occurs: `par_in` → `sreg` directly (bypass), `cnt←0`, SHIFT.
  - Otherwise: next state IDLE.
- A par handshake that does not bypass writes the hold buffer and sets `hold_full`.
- Beat with `cnt<NUM-1`: `sreg` shifts by SER_WIDTH toward the output end and `cnt` increments.
- Output order is MSB-first: `ser_out = sreg[PAR_WIDTH-1 -: SER_WIDTH]`, so a downstream SIPO rebuilds the identical word.
- Derived outputs:
  - `ser_valid` = (state==SHIFT).
  - `ser_first` = SHIFT && `cnt==0`.
  - `ser_last` = SHIFT && `cnt==NUM-1`.
  - `busy` = SHIFT || `hold_full`.
- When NUM=1, `ser_first` and `ser_last` are both high on every beat.
- `ser_out`, `ser_first` and `ser_last` must stay stable while `ser_valid && !ser_ready`.

## Timing
- Reset values while `reset`=0:
  - state IDLE, `cnt`=0, `hold_full`=0, `sreg`=0, hold=0.
  - `ser_out`=0, `ser_valid`=0, `ser_first`=0, `ser_last`=0, `busy`=0.
  - `par_ready`=0.
- In the first cycle after reset, `par_ready`=1.
- Reset in mid-word discards both the active word and the held word. No partial beat follows.
- Latency: a par handshake in cycle t gives `ser_valid`=1 with chunk 0 in cycle t+1, when the bypass applies.
- Throughput: with `ser_ready` held at 1, consecutive words produce a continuous beat stream with no idle cycle. `par_ready` may drop for at most one word time.
- Simultaneous events: a final beat, a par handshake and an empty hold in the same cycle cause a bypass load. The next word's chunk 0 appears the next cycle.
- Full condition: with `hold_full` and SHIFT both set, `par_ready`=0 until the final beat of the active word.

## Configuration
- `PISO_BAR_LSB_FIRST_EN` defined: output is LSB-first. `ser_out = sreg[SER_WIDTH-1:0]` and the shift runs toward bit 0. The first/last markers and the timing are unchanged.
- Macro undefined: MSB-first, as described in Operation.

## Structure
- `def_params.vh` provides `DATA_WIDTH`, `IF_WIDTH`, `KERNEL_WIDTH` and `C_LOG_2`. The state encoding (IDLE/SHIFT) is added there as shared localparams.
- One natural sub-module: `piso_hold`, the one-word hold buffer with its full flag, load and pop.

## Test plan
Bench configuration: SER_WIDTH=8, PAR_WIDTH=24, NUM=3.
- Single word 0xAABBCC, `ser_ready`=1 → beats AA, BB, CC in cycles t+1..t+3; `ser_first` on AA, `ser_last` on CC; then `ser_valid`=0.
- Words 0x112233 then 0x445566 offered back-to-back, `ser_ready`=1 → 6 consecutive beats 11,22,33,44,55,66 with no gap; `par_ready` low while the hold buffer is full.
- `ser_ready`=0 for 3 cycles after beat AA → `ser_out`=BB and `ser_valid`=1 held stable; the stream resumes BB, CC with no loss.
- Assert `reset`=0 after beat 11 of 0x112233 while 0x445566 is held → all outputs 0; after release, `busy`=0 and no further beats appear.
- Loopback into `sipo_bar` (same widths, `begin_serial_in` = `ser_first && ser_valid`) → the reconstructed `parallel_array` equals 0xAABBCC.
- With `PISO_BAR_LSB_FIRST_EN` defined, word 0xAABBCC → beats CC, BB, AA.
